bus_timer: RTL
==============

Name: bus_timer

Overview:
- Memory-mapped timer peripheral. Acts as a follower (responder) on the system bus and is instantiated as one of the system_bus followers.
- Provides a prescaled 32-bit up-counter, a compare register, a sticky match flag and a level interrupt.
- Gives leaders (CPU, test harnesses) a cycle-accurate time base and a periodic event source.

Parameters:
- PrescaleWidth, 16, width of the PRESCALE register and the internal prescaler counter.
- ResetCompare, 32'hFFFF_FFFF, reset value of COMPARE.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- bus  follower modport of bus  —  addr[31:0], read_req, write_req, byte_enable[3:0], write_data[31:0] in; read_data[31:0], read_data_valid out.
- irq  output  1  level interrupt, equal to match_flag & CTRL.irq_en.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Decode uses addr[4:2] only; upper bits are already decoded by system_bus. Register map (word offsets):
  - 0x00 CTRL: [0] enable, [1] auto_reload, [2] irq_en; other bits read 0.
  - 0x04 PRESCALE: [PrescaleWidth-1:0]. One tick is issued every PRESCALE+1 enabled cycles.
  - 0x08 COUNT: 32-bit counter, read/write.
  - 0x0C COMPARE: 32-bit compare value, read/write.
  - 0x10 STATUS: [0] match_flag, write-1-to-clear.
  - Any other offset: reads return 0, writes are ignored.
- Reset values:
  - CTRL=0, PRESCALE=0, COUNT=0, COMPARE=ResetCompare, match_flag=0, prescaler counter=0.
  - read_data=0, read_data_valid=0, irq=0.
- Read handshake:
  - read_req sampled at edge N.
  - read_data_valid=1 for exactly one cycle after edge N; read_data holds the register value as of edge N (pre-update).
  - Zero wait states, no backpressure. Back-to-back reads every cycle are supported.
  - read_data=0 whenever read_data_valid=0.
- Write handshake:
  - write_req sampled at edge N; the register updates at edge N. No response signal.
  - byte_enable[i] gates write_data[8i+7:8i].
  - STATUS clear uses only byte lane 0, bit 0.
- read_req and write_req in the same cycle: both are performed, and the read returns the pre-write value.
- Prescaler:
  - enable=0: prescaler counter held at 0, no ticks.
  - enable=1: counter increments each cycle. When it equals PRESCALE, tick=1 and the counter returns to 0.
  - Any write to PRESCALE (any byte lane) also zeroes the prescaler counter.
- On a tick:
  - If COUNT==COMPARE: match_flag<=1; COUNT<=auto_reload ? 0 : COUNT+1.
  - Otherwise: COUNT<=COUNT+1.
  - Arithmetic is modulo 2^32 (32'hFFFF_FFFF+1 wraps to 0, with no flag).
- Simultaneous events:
  - Bus write to COUNT in a tick cycle: the written value wins and the increment is dropped. The match check uses the pre-write COUNT.
  - W1C of match_flag in the same cycle as a new match: set wins, flag stays 1.
  - Write to CTRL clearing enable in a tick cycle: that tick is still applied.
- Reset mid-operation: all state returns to reset values at the next edge. A pending read_data_valid is dropped.
- irq is combinational from registered state; no extra latency beyond the match_flag register.

Decomposition:
- timer_pkg holds:
  - offset constants TIMER_CTRL/PRESCALE/COUNT/COMPARE/STATUS;
  - CTRL bit indices CTRL_ENABLE=0, CTRL_AUTO_RELOAD=1, CTRL_IRQ_EN=2;
  - a byte-enable merge function (old, new, be) -> merged word.
- Sub-module timer_prescaler (clk, reset, enable, clear, prescale, tick) contains the prescaler counter. Register file, counter and bus response stay in bus_timer.

Test Plan:
- Reset, then read all five offsets plus 0x14:
  - returns 0, 0, 0, FFFF_FFFF, 0, 0;
  - read_data_valid exactly one cycle after each read_req.
- PRESCALE=0, COMPARE=3, CTRL=0x5:
  - COUNT increments every cycle; match_flag and irq rise one cycle after COUNT==3 ticks;
  - COUNT continues to 4, 5, …
- PRESCALE=2, CTRL=0x3, COMPARE=2:
  - COUNT increments every 3 cycles and sequence is 0,1,2,0,1,2;
  - match_flag set at first wrap.
- Write STATUS=1 in the same cycle a match occurs -> flag remains 1. Write STATUS=1 on a later non-match cycle -> flag 0, irq 0.
- Write COUNT=0xAABBCCDD with byte_enable=4'h2 over COUNT=0 (counter disabled) -> readback 0x0000CC00.
- COUNT=FFFF_FFFF, COMPARE=5, enable, PRESCALE=0 -> next COUNT=0, match_flag stays 0. Then assert reset mid-count -> all registers back to reset values.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants and helpers for the bus timer peripheral.
package timer_pkg;

    // Word offsets, decoded from addr[4:2]
    localparam logic [2:0] TIMER_CTRL     = 3'd0;
    localparam logic [2:0] TIMER_PRESCALE = 3'd1;
    localparam logic [2:0] TIMER_COUNT    = 3'd2;
    localparam logic [2:0] TIMER_COMPARE  = 3'd3;
    localparam logic [2:0] TIMER_STATUS   = 3'd4;

    // CTRL bit positions
    localparam int unsigned CTRL_ENABLE      = 0;
    localparam int unsigned CTRL_AUTO_RELOAD = 1;
    localparam int unsigned CTRL_IRQ_EN      = 2;

    // Replace only the byte lanes selected by be
    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: issues one tick every prescale+1 enabled cycles.
module timer_prescaler #(
    parameter int unsigned PrescaleWidth = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [PrescaleWidth-1:0] prescale,
    output logic                     tick
);

    logic [PrescaleWidth-1:0] cnt_q;

    assign tick = enable && (cnt_q == prescale);

    // Count enabled cycles; wrap on tick, hold at zero when disabled or cleared
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear || !enable || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped prescaled 32-bit timer with compare, sticky match flag and irq.
module bus_timer
    import timer_pkg::*;
#(
    parameter int unsigned PrescaleWidth = 16,
    parameter logic [31:0] ResetCompare  = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        read_req,
    input  logic        write_req,
    input  logic [3:0]  byte_enable,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        read_data_valid,
    output logic        irq
);

    logic [2:0]               ctrl_q, ctrl_d;
    logic [PrescaleWidth-1:0] prescale_q, prescale_d;
    logic [31:0]              count_q, count_d;
    logic [31:0]              compare_q, compare_d;
    logic                     match_q, match_d;
    logic [31:0]              rd_word;
    logic [2:0]               offset;
    logic                     tick;
    logic                     wr_prescale;

    // Upper address bits are decoded by the system bus
    logic unused_addr;
    assign unused_addr = ^{addr[31:5], addr[1:0]};

    assign offset      = addr[4:2];
    assign wr_prescale = write_req && (offset == TIMER_PRESCALE);
    assign irq         = match_q && ctrl_q[CTRL_IRQ_EN];

    timer_prescaler #(
        .PrescaleWidth(PrescaleWidth)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .enable  (ctrl_q[CTRL_ENABLE]),
        .clear   (wr_prescale),
        .prescale(prescale_q),
        .tick    (tick)
    );

    // Read mux over the pre-update register values
    always_comb begin
        rd_word = '0;
        case (offset)
            TIMER_CTRL:     rd_word = {29'b0, ctrl_q};
            TIMER_PRESCALE: rd_word = 32'(prescale_q);
            TIMER_COUNT:    rd_word = count_q;
            TIMER_COMPARE:  rd_word = compare_q;
            TIMER_STATUS:   rd_word = {31'b0, match_q};
            default:        rd_word = '0;
        endcase
    end

    // Next-state: tick effects first, bus writes override
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        count_d    = count_q;
        compare_d  = compare_q;
        match_d    = match_q;

        if (write_req && offset == TIMER_STATUS && byte_enable[0] && write_data[0]) begin
            match_d = 1'b0;
        end

        if (tick) begin
            if (count_q == compare_q) begin
                match_d = 1'b1;  // set beats a same-cycle W1C
                count_d = ctrl_q[CTRL_AUTO_RELOAD] ? 32'd0 : count_q + 32'd1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        if (write_req) begin
            case (offset)
                TIMER_CTRL:
                    ctrl_d = 3'(be_merge({29'b0, ctrl_q}, write_data, byte_enable));
                TIMER_PRESCALE:
                    prescale_d = PrescaleWidth'(be_merge(32'(prescale_q), write_data,
                                                         byte_enable));
                TIMER_COUNT:
                    count_d = be_merge(count_q, write_data, byte_enable);
                TIMER_COMPARE:
                    compare_d = be_merge(compare_q, write_data, byte_enable);
                default: ;
            endcase
        end
    end

    // Register file and status flag
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            count_q    <= '0;
            compare_q  <= ResetCompare;
            match_q    <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
        end
    end

    // Single-cycle read response; data is zero when not valid
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data       <= '0;
            read_data_valid <= 1'b0;
        end else begin
            read_data       <= read_req ? rd_word : 32'd0;
            read_data_valid <= read_req;
        end
    end

endmodule
